// File: rtl/mole_hit_scorer.sv
// Whack-a-mole hit/miss scorer: raises a pseudo-random mole on each mole_clk rise,
// judges player whacks and keeps saturating score/miss counters.
module mole_hit_scorer #(
    parameter int         NUM_MOLES = 4,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int         MAX_SCORE = 99,
    parameter int         SCORE_W   = $clog2(MAX_SCORE + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 game_in_progress,
    input  logic                 mole_clk,
    input  logic [NUM_MOLES-1:0] whack_buttons,
    output logic [NUM_MOLES-1:0] mole_leds,
    output logic [SCORE_W-1:0]   score,
    output logic [SCORE_W-1:0]   misses,
    output logic                 hit_pulse,
    output logic                 miss_pulse
);

    localparam int                 POS_W     = (NUM_MOLES > 2) ? $clog2(NUM_MOLES) : 1;
    localparam logic [7:0]         SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(MAX_SCORE);

    typedef enum logic [1:0] {IDLE, HIDDEN, UP, HIT} state_t;

    state_t               state, state_next;
    logic [7:0]           lfsr, lfsr_next;
    logic [POS_W-1:0]     last_pos, pick_raw, pick;
    logic                 mole_q, mole_rise, mole_fall;
    logic [NUM_MOLES-1:0] btn_q, btn_rise, lit_mask;
    logic                 hit_ev, miss_ev, latch_pos;

    assign mole_rise = mole_clk & ~mole_q;
    assign mole_fall = ~mole_clk & mole_q;
    assign btn_rise  = whack_buttons & ~btn_q;
    assign lit_mask  = NUM_MOLES'(1) << last_pos;
    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 8'hB8) : (lfsr >> 1);

    // Never light the same hole twice in a row.
    always_comb begin
        pick_raw = POS_W'(32'(lfsr) % NUM_MOLES);
        pick     = pick_raw;
        if (pick_raw == last_pos)
            pick = (pick_raw == POS_W'(NUM_MOLES - 1)) ? '0 : pick_raw + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr     <= SEED;
            mole_q   <= 1'b0;
            btn_q    <= '0;
            last_pos <= '0;
        end else begin
            lfsr   <= lfsr_next;
            mole_q <= mole_clk;
            btn_q  <= whack_buttons;
            if (latch_pos)
                last_pos <= pick;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        hit_ev     = 1'b0;
        miss_ev    = 1'b0;
        latch_pos  = 1'b0;
        if (clear || !game_in_progress) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: state_next = HIDDEN;
                HIDDEN: begin
                    miss_ev = |btn_rise;
                    if (mole_rise) begin
                        latch_pos  = 1'b1;
                        state_next = UP;
                    end
                end
                UP: begin
                    // A correct whack wins over any wrong button or escape in the same cycle.
                    if (|(btn_rise & lit_mask)) begin
                        hit_ev     = 1'b1;
                        state_next = mole_fall ? HIDDEN : HIT;
                    end else begin
                        miss_ev = (|btn_rise) | mole_fall;
                        if (mole_fall)
                            state_next = HIDDEN;
                    end
                end
                HIT: begin
                    if (mole_fall)
                        state_next = HIDDEN;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        mole_leds = (state == UP) ? lit_mask : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score      <= '0;
            misses     <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else if (clear) begin
            score      <= '0;
            misses     <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            hit_pulse  <= hit_ev;
            miss_pulse <= miss_ev;
            if (hit_ev && score != SCORE_MAX)
                score <= score + 1'b1;
            if (miss_ev && misses != SCORE_MAX)
                misses <= misses + 1'b1;
        end
    end

endmodule

// File: tb/tb_mole_hit_scorer.sv
// Randomised self-checking bench for mole_hit_scorer against a scenario-level model.
module tb_mole_hit_scorer;

    localparam int NUM = 4;
    localparam int MAX = 99;
    localparam int SW  = $clog2(MAX + 1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           clear = 1'b0;
    logic           game_in_progress = 1'b0;
    logic           mole_clk = 1'b0;
    logic [NUM-1:0] whack_buttons = '0;
    logic [NUM-1:0] mole_leds;
    logic [SW-1:0]  score, misses;
    logic           hit_pulse, miss_pulse;

    int checks = 0;
    int failures = 0;
    int m_score = 0;
    int m_miss = 0;
    int m_last = 0;
    logic [7:0] m_lfsr;

    mole_hit_scorer #(.NUM_MOLES(NUM), .LFSR_SEED(8'hA5), .MAX_SCORE(MAX)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .game_in_progress(game_in_progress),
        .mole_clk(mole_clk), .whack_buttons(whack_buttons), .mole_leds(mole_leds),
        .score(score), .misses(misses), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
    );

    always #5 clk = ~clk;

    // Reference Galois LFSR (mask B8, shift right), free-running from reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
    end

    function automatic int sat(input int v);
        return (v < MAX) ? v + 1 : MAX;
    endfunction

    function automatic int predict();
        int p;
        p = int'(m_lfsr) % NUM;
        if (p == m_last) p = (p + 1) % NUM;
        return p;
    endfunction

    function automatic logic [NUM-1:0] wrong_mask(input int p);
        logic [NUM-1:0] m;
        m = NUM'($urandom_range(1, (1 << NUM) - 1)) & ~(NUM'(1) << p);
        if (m == '0) m = NUM'(1) << ((p + 1) % NUM);
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop(output int p);
        mole_clk = 1'b1;
        p = predict();
        tick();
        m_last = p;
    endtask

    task automatic drop();
        mole_clk = 1'b0;
        tick();
    endtask

    task automatic press(input logic [NUM-1:0] m);
        whack_buttons = m;
        tick();
    endtask

    task automatic release_btn();
        whack_buttons = '0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (mole_leds !== '0) begin failures++; $display("FAIL reset_leds got=%0h exp=0", mole_leds); end
        checks++; if (score !== '0 || misses !== '0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", score, misses); end
        checks++; if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%b%b exp=00", hit_pulse, miss_pulse); end
        checks++; if (dut.lfsr !== 8'hA5) begin failures++; $display("FAIL reset_lfsr got=%0h exp=a5", dut.lfsr); end
        rst_n = 1'b1;
        m_score = 0; m_miss = 0; m_last = 0;
        tick();
        game_in_progress = 1'b1;
        tick();
    endtask

    task automatic test_hit();
        int p;
        pop(p);
        checks++; if (mole_leds !== NUM'(1) << p) begin failures++; $display("FAIL hit_led got=%0h exp=%0h", mole_leds, NUM'(1) << p); end
        press(NUM'(1) << p);
        m_score = sat(m_score);
        checks++; if (hit_pulse !== 1'b1 || int'(score) !== m_score) begin failures++; $display("FAIL hit_score got=%b/%0d exp=1/%0d", hit_pulse, score, m_score); end
        checks++; if (mole_leds !== '0) begin failures++; $display("FAIL hit_led_off got=%0h exp=0", mole_leds); end
        release_btn();
        checks++; if (hit_pulse !== 1'b0 || mole_leds !== '0) begin failures++; $display("FAIL hit_one_cycle got=%b/%0h exp=0/0", hit_pulse, mole_leds); end
        drop();
        checks++; if (miss_pulse !== 1'b0 || int'(misses) !== m_miss) begin failures++; $display("FAIL hit_fall got=%b/%0d exp=0/%0d", miss_pulse, misses, m_miss); end
    endtask

    task automatic test_wrong_escape();
        int p;
        logic [NUM-1:0] w;
        press(NUM'(1) << $urandom_range(0, NUM - 1));
        m_miss = sat(m_miss);
        checks++; if (miss_pulse !== 1'b1 || int'(misses) !== m_miss) begin failures++; $display("FAIL hidden_whack got=%b/%0d exp=1/%0d", miss_pulse, misses, m_miss); end
        release_btn();
        pop(p);
        w = wrong_mask(p);
        press(w);
        m_miss = sat(m_miss);
        checks++; if (int'(misses) !== m_miss || miss_pulse !== 1'b1) begin failures++; $display("FAIL wrong_miss got=%0d exp=%0d", misses, m_miss); end
        checks++; if (mole_leds !== NUM'(1) << p) begin failures++; $display("FAIL wrong_led got=%0h exp=%0h", mole_leds, NUM'(1) << p); end
        release_btn();
        drop();
        m_miss = sat(m_miss);
        checks++; if (int'(misses) !== m_miss || miss_pulse !== 1'b1 || mole_leds !== '0) begin failures++; $display("FAIL escape got=%0d/%0h exp=%0d/0", misses, mole_leds, m_miss); end
    endtask

    task automatic test_simultaneous();
        int p, q;
        pop(p);
        whack_buttons = '1;
        mole_clk = 1'b0;
        tick();
        m_score = sat(m_score);
        checks++; if (int'(score) !== m_score || int'(misses) !== m_miss) begin failures++; $display("FAIL simul_cnt got=%0d/%0d exp=%0d/%0d", score, misses, m_score, m_miss); end
        checks++; if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0) begin failures++; $display("FAIL simul_pulse got=%b%b exp=10", hit_pulse, miss_pulse); end
        release_btn();
        checks++; if (hit_pulse !== 1'b0) begin failures++; $display("FAIL simul_once got=%b exp=0", hit_pulse); end
        pop(q);
        checks++; if (mole_leds !== NUM'(1) << q) begin failures++; $display("FAIL simul_hidden got=%0h exp=%0h", mole_leds, NUM'(1) << q); end
        drop();
        m_miss = sat(m_miss);
    endtask

    task automatic test_random();
        int p, kind;
        for (int i = 0; i < 40; i++) begin
            pop(p);
            checks++; if (mole_leds !== NUM'(1) << p) begin failures++; $display("FAIL rnd_led i=%0d got=%0h exp=%0h", i, mole_leds, NUM'(1) << p); end
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                press(NUM'(1) << p);
                m_score = sat(m_score);
            end else if (kind == 1) begin
                press(wrong_mask(p));
                m_miss = sat(m_miss);
            end
            if (kind != 2) release_btn();
            drop();
            if (kind != 0) m_miss = sat(m_miss);
            checks++; if (int'(score) !== m_score || int'(misses) !== m_miss) begin failures++; $display("FAIL rnd_cnt i=%0d got=%0d/%0d exp=%0d/%0d", i, score, misses, m_score, m_miss); end
        end
        checks++; if (dut.lfsr !== m_lfsr) begin failures++; $display("FAIL rnd_lfsr got=%0h exp=%0h", dut.lfsr, m_lfsr); end
    endtask

    task automatic test_saturation();
        int p, hp;
        hp = 0;
        for (int i = 0; i < 101; i++) begin
            pop(p);
            press(NUM'(1) << p);
            hp += int'(hit_pulse);
            release_btn();
            hp += int'(hit_pulse);
            drop();
            hp += int'(hit_pulse);
            m_score = sat(m_score);
        end
        checks++; if (int'(score) !== MAX) begin failures++; $display("FAIL sat_score got=%0d exp=%0d", score, MAX); end
        checks++; if (hp !== 101) begin failures++; $display("FAIL sat_pulses got=%0d exp=101", hp); end
        for (int i = 0; i < 101; i++) begin
            pop(p);
            drop();
            m_miss = sat(m_miss);
        end
        checks++; if (int'(misses) !== MAX || miss_pulse !== 1'b1) begin failures++; $display("FAIL sat_misses got=%0d/%b exp=%0d/1", misses, miss_pulse, MAX); end
    endtask

    task automatic test_no_repeat_clear();
        int p;
        logic [NUM-1:0] prev;
        prev = '0;
        for (int i = 0; i < 50; i++) begin
            pop(p);
            checks++; if (mole_leds === prev || mole_leds !== NUM'(1) << p) begin failures++; $display("FAIL norepeat i=%0d got=%0h prev=%0h exp=%0h", i, mole_leds, prev, NUM'(1) << p); end
            prev = mole_leds;
            drop();
        end
        m_miss = (m_miss + 50 > MAX) ? MAX : m_miss + 50;
        pop(p);
        clear = 1'b1;
        tick();
        m_score = 0; m_miss = 0;
        checks++; if (score !== '0 || misses !== '0 || mole_leds !== '0) begin failures++; $display("FAIL clear got=%0d/%0d/%0h exp=0/0/0", score, misses, mole_leds); end
        checks++; if (dut.lfsr !== m_lfsr) begin failures++; $display("FAIL clear_lfsr got=%0h exp=%0h", dut.lfsr, m_lfsr); end
        clear = 1'b0;
        game_in_progress = 1'b0;
        mole_clk = 1'b0;
        tick();
        press(NUM'(1) << $urandom_range(0, NUM - 1));
        checks++; if (miss_pulse !== 1'b0 || misses !== '0) begin failures++; $display("FAIL idle_whack got=%b/%0d exp=0/0", miss_pulse, misses); end
        release_btn();
    endtask

    task automatic test_game_stop();
        int p;
        game_in_progress = 1'b1;
        tick();
        pop(p);
        press(NUM'(1) << p);
        release_btn();
        drop();
        m_score = sat(m_score);
        pop(p);
        game_in_progress = 1'b0;
        tick();
        checks++; if (mole_leds !== '0 || int'(score) !== m_score || int'(misses) !== m_miss) begin failures++; $display("FAIL gip_low got=%0h/%0d/%0d exp=0/%0d/%0d", mole_leds, score, misses, m_score, m_miss); end
        game_in_progress = 1'b1;
        drop();
        pop(p);
    endtask

    task automatic test_reset_midround();
        checks++; if (mole_leds === '0) begin failures++; $display("FAIL midrst_pre got=%0h exp=nonzero", mole_leds); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (mole_leds !== '0 || score !== '0 || misses !== '0) begin failures++; $display("FAIL midrst got=%0h/%0d/%0d exp=0/0/0", mole_leds, score, misses); end
        checks++; if (dut.lfsr !== 8'hA5) begin failures++; $display("FAIL midrst_lfsr got=%0h exp=a5", dut.lfsr); end
        mole_clk = 1'b0;
        game_in_progress = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_hit();
        test_wrong_escape();
        test_simultaneous();
        test_random();
        test_saturation();
        test_no_repeat_clear();
        test_game_stop();
        test_reset_midround();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
